// File: rtl/mem_port_arbiter_if.sv
// Bundle of the fetch, LSU and memory-side handshake signals around the memory port arbiter.
// The slave view is the arbiter; the master view is whatever drives requests and models memory.
interface mem_port_arbiter_if #(
  parameter int AW = 32,
  parameter int DW = 32
);
  logic            if_req_i;
  logic [AW-1:0]   if_addr_i;
  logic            if_gnt_o;
  logic            if_rvalid_o;
  logic [DW-1:0]   if_rdata_o;

  logic            lsu_rd_en_i;
  logic            lsu_wr_en_i;
  logic [AW-1:0]   lsu_addr_i;
  logic [DW-1:0]   lsu_wdata_i;
  logic [DW/8-1:0] lsu_be_i;
  logic            lsu_gnt_o;
  logic            lsu_rvalid_o;
  logic [DW-1:0]   lsu_rdata_o;

  logic            mem_req_o;
  logic            mem_we_o;
  logic [AW-1:0]   mem_addr_o;
  logic [DW-1:0]   mem_wdata_o;
  logic [DW/8-1:0] mem_be_o;
  logic            mem_ack_i;
  logic [DW-1:0]   mem_rdata_i;

  logic            busy_o;

  modport slave (
    input  if_req_i, if_addr_i,
    output if_gnt_o, if_rvalid_o, if_rdata_o,
    input  lsu_rd_en_i, lsu_wr_en_i, lsu_addr_i, lsu_wdata_i, lsu_be_i,
    output lsu_gnt_o, lsu_rvalid_o, lsu_rdata_o,
    output mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o, mem_be_o,
    input  mem_ack_i, mem_rdata_i,
    output busy_o
  );

  modport master (
    output if_req_i, if_addr_i,
    input  if_gnt_o, if_rvalid_o, if_rdata_o,
    output lsu_rd_en_i, lsu_wr_en_i, lsu_addr_i, lsu_wdata_i, lsu_be_i,
    input  lsu_gnt_o, lsu_rvalid_o, lsu_rdata_o,
    input  mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o, mem_be_o,
    output mem_ack_i, mem_rdata_i,
    input  busy_o
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Arbitrates the single-port memory between instruction fetch and the LSU, one access at a time.
// LSU wins by default; a starvation counter forces an IF grant after MAX_STARVE LSU wins in a row.
module mem_port_arbiter #(
  parameter int AW         = 32,
  parameter int DW         = 32,
  parameter int MAX_STARVE = 3
) (
  input logic               clk_i,
  input logic               rst_ni,
  mem_port_arbiter_if.slave bus
);
  localparam int         BW         = DW / 8;
  localparam logic [3:0] STARVE_LIM = 4'(MAX_STARVE);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2
  } state_t;

  function automatic logic [3:0] starve_inc(input logic [3:0] cnt);
    return (cnt >= STARVE_LIM) ? STARVE_LIM : cnt + 4'd1;
  endfunction

  state_t          state_q, state_d;
  logic [3:0]      starve_q;
  logic            owner_lsu_q;
  logic            we_q;
  logic [AW-1:0]   addr_q;
  logic [DW-1:0]   wdata_q;
  logic [BW-1:0]   be_q;
  logic [DW-1:0]   if_rdata_q;
  logic [DW-1:0]   lsu_rdata_q;

  logic            lsu_req;
  logic            lsu_win;
  logic            if_win;

  // Arbitration is only open in IDLE; grants are combinational from the live requests.
  always_comb begin
    lsu_req = bus.lsu_rd_en_i | bus.lsu_wr_en_i;
    lsu_win = 1'b0;
    if_win  = 1'b0;
    if (state_q == IDLE) begin
      lsu_win = lsu_req && ((starve_q < STARVE_LIM) || !bus.if_req_i);
      if_win  = !lsu_win && bus.if_req_i;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (lsu_win || if_win) state_d = ISSUE;
      ISSUE:   if (bus.mem_ack_i)     state_d = RESP;
      RESP:                           state_d = IDLE;
      default:                        state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) state_q <= IDLE;
    else         state_q <= state_d;
  end

  // Transaction capture at grant; a simultaneous load+store request is taken as a store.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      starve_q    <= 4'd0;
      owner_lsu_q <= 1'b0;
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      be_q        <= '0;
    end else if (lsu_win) begin
      starve_q    <= bus.if_req_i ? starve_inc(starve_q) : 4'd0;
      owner_lsu_q <= 1'b1;
      we_q        <= bus.lsu_wr_en_i;
      addr_q      <= bus.lsu_addr_i;
      wdata_q     <= bus.lsu_wr_en_i ? bus.lsu_wdata_i : '0;
      be_q        <= bus.lsu_wr_en_i ? bus.lsu_be_i : '1;
    end else if (if_win) begin
      starve_q    <= 4'd0;
      owner_lsu_q <= 1'b0;
      we_q        <= 1'b0;
      addr_q      <= bus.if_addr_i;
      wdata_q     <= '0;
      be_q        <= '1;
    end
  end

  // Response data is captured on ack and held until the owner's next response.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      if_rdata_q  <= '0;
      lsu_rdata_q <= '0;
    end else if (state_q == ISSUE && bus.mem_ack_i) begin
      if (owner_lsu_q) lsu_rdata_q <= we_q ? '0 : bus.mem_rdata_i;
      else             if_rdata_q  <= bus.mem_rdata_i;
    end
  end

  assign bus.if_gnt_o     = if_win;
  assign bus.lsu_gnt_o    = lsu_win;
  assign bus.if_rvalid_o  = (state_q == RESP) && !owner_lsu_q;
  assign bus.lsu_rvalid_o = (state_q == RESP) && owner_lsu_q;
  assign bus.if_rdata_o   = if_rdata_q;
  assign bus.lsu_rdata_o  = lsu_rdata_q;

  assign bus.mem_req_o    = (state_q == ISSUE);
  assign bus.mem_we_o     = we_q;
  assign bus.mem_addr_o   = addr_q;
  assign bus.mem_wdata_o  = wdata_q;
  assign bus.mem_be_o     = be_q;

  assign bus.busy_o       = (state_q != IDLE);
endmodule
